// File: rtl/brew_sequencer.sv
// Coin credit, price check, change and timed valve sequencing for the vending datapath.
// Credit and pulses register one cycle after the sampled edge. There is no backpressure: inputs are sampled every cycle.
module brew_sequencer #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int CREDIT_MAX    = 10,
  parameter int FINISH_SECS   = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       coin_100,
  input  logic       coin_500,
  input  logic [1:0] coffee_type,
  input  logic       start,
  input  logic       cancel,
  output logic [3:0] credit,
  output logic [3:0] change,
  output logic       change_valid,
  output logic       coin_reject,
  output logic       insufficient,
  output logic       water,
  output logic       coffee,
  output logic       sugar,
  output logic       milk,
  output logic       chocolate,
  output logic       finished,
  output logic       busy,
  output logic [2:0] state
);

  localparam int MAX_SECS = (FINISH_SECS > 3) ? FINISH_SECS : 3;
  localparam int TW       = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int SW       = $clog2(MAX_SECS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WATER  = 3'd1,
    COFFEE = 3'd2,
    SUGAR  = 3'd3,
    MILK   = 3'd4,
    CHOC   = 3'd5,
    DONE   = 3'd6
  } state_t;

  function automatic logic [3:0] price_of(input logic [1:0] t);
    case (t)
      2'd0:    price_of = 4'd4;
      2'd1:    price_of = 4'd6;
      2'd2:    price_of = 4'd7;
      default: price_of = 4'd5;
    endcase
  endfunction

  // Row packs per-step seconds as {water, coffee, sugar, milk, chocolate}.
  function automatic logic [1:0] dur_of(input logic [1:0] t, input state_t s);
    logic [9:0] row;
    case (t)
      2'd0:    row = {2'd3, 2'd2, 2'd1, 2'd0, 2'd0};
      2'd1:    row = {2'd1, 2'd2, 2'd1, 2'd3, 2'd0};
      2'd2:    row = {2'd1, 2'd2, 2'd1, 2'd2, 2'd3};
      default: row = {2'd1, 2'd1, 2'd0, 2'd3, 2'd0};
    endcase
    case (s)
      WATER:   dur_of = row[9:8];
      COFFEE:  dur_of = row[7:6];
      SUGAR:   dur_of = row[5:4];
      MILK:    dur_of = row[3:2];
      CHOC:    dur_of = row[1:0];
      default: dur_of = 2'd0;
    endcase
  endfunction

  function automatic state_t step_after(input logic [1:0] t, input state_t s);
    state_t nxt;
    nxt = DONE;
    for (int i = 5; i >= 1; i--) begin
      if (i > int'(s) && dur_of(t, state_t'(i[2:0])) != 2'd0) begin
        nxt = state_t'(i[2:0]);
      end
    end
    return nxt;
  endfunction

  state_t        state_q, state_d;
  logic [3:0]    credit_q, credit_d;
  logic [3:0]    change_q, change_d;
  logic [1:0]    type_q, type_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [SW-1:0] sec_q, sec_d;
  logic          cv_q, cv_d;
  logic          rej_q, rej_d;
  logic          ins_q, ins_d;
  logic          prev100_q, prev500_q;

  logic          edge_100, edge_500, coin_edge, start_ok;
  logic [2:0]    delta;
  logic [3:0]    base;
  logic [4:0]    sum;
  logic [SW-1:0] step_secs;

  assign edge_100  = coin_100 & ~prev100_q;
  assign edge_500  = coin_500 & ~prev500_q;
  assign coin_edge = edge_100 | edge_500;
  assign delta     = 3'(edge_100) + (edge_500 ? 3'd5 : 3'd0);

  always_comb begin
    state_d   = state_q;
    change_d  = change_q;
    type_d    = type_q;
    tick_d    = tick_q;
    sec_d     = sec_q;
    cv_d      = 1'b0;
    rej_d     = 1'b0;
    ins_d     = 1'b0;
    base      = credit_q;
    start_ok  = 1'b0;
    step_secs = (state_q == DONE) ? SW'(FINISH_SECS) : SW'(dur_of(type_q, state_q));

    case (state_q)
      IDLE: begin
        tick_d = '0;
        sec_d  = '0;
        if (cancel) begin
          if (credit_q != 4'd0) begin
            change_d = credit_q;
            cv_d     = 1'b1;
            base     = '0;
          end
        end else if (start) begin
          if (credit_q >= price_of(coffee_type)) begin
            start_ok = 1'b1;
            type_d   = coffee_type;
            change_d = credit_q - price_of(coffee_type);
            cv_d     = 1'b1;
            base     = '0;
            state_d  = step_after(coffee_type, IDLE);
          end else begin
            ins_d = 1'b1;
          end
        end
      end
      WATER, COFFEE, SUGAR, MILK, CHOC, DONE: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (sec_q + SW'(1) == step_secs) begin
            sec_d   = '0;
            state_d = (state_q == DONE) ? IDLE : step_after(type_q, state_q);
          end else begin
            sec_d = sec_q + SW'(1);
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tick_d  = '0;
        sec_d   = '0;
      end
    endcase

    // A combined 100+500 edge is accepted or refused as one unit.
    sum      = {1'b0, base} + {2'b00, delta};
    credit_d = base;
    if (coin_edge) begin
      if (state_q == IDLE && !start_ok && sum <= 5'(CREDIT_MAX)) begin
        credit_d = sum[3:0];
      end else begin
        rej_d = 1'b1;
      end
    end
  end

  // Edge detectors preload high so a coin held during reset is not counted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      credit_q  <= '0;
      change_q  <= '0;
      type_q    <= '0;
      tick_q    <= '0;
      sec_q     <= '0;
      cv_q      <= 1'b0;
      rej_q     <= 1'b0;
      ins_q     <= 1'b0;
      prev100_q <= 1'b1;
      prev500_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      credit_q  <= credit_d;
      change_q  <= change_d;
      type_q    <= type_d;
      tick_q    <= tick_d;
      sec_q     <= sec_d;
      cv_q      <= cv_d;
      rej_q     <= rej_d;
      ins_q     <= ins_d;
      prev100_q <= coin_100;
      prev500_q <= coin_500;
    end
  end

  assign credit       = credit_q;
  assign change       = change_q;
  assign change_valid = cv_q;
  assign coin_reject  = rej_q;
  assign insufficient = ins_q;
  assign water        = (state_q == WATER);
  assign coffee       = (state_q == COFFEE);
  assign sugar        = (state_q == SUGAR);
  assign milk         = (state_q == MILK);
  assign chocolate    = (state_q == CHOC);
  assign finished     = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign state        = state_q;

endmodule

// File: tb/tb_brew_sequencer.sv
// Scoreboarded bench for brew_sequencer: directed scenarios followed by a randomized coin/start/cancel mix.
module tb_brew_sequencer;
  localparam int TPS   = 4;
  localparam int CMAX  = 10;
  localparam int FSECS = 1;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       coin_100 = 1'b0;
  logic       coin_500 = 1'b0;
  logic [1:0] coffee_type = 2'd0;
  logic       start = 1'b0;
  logic       cancel = 1'b0;
  logic [3:0] credit, change;
  logic       change_valid, coin_reject, insufficient;
  logic       water, coffee, sugar, milk, chocolate, finished, busy;
  logic [2:0] state;

  brew_sequencer #(.TICKS_PER_SEC(TPS), .CREDIT_MAX(CMAX), .FINISH_SECS(FSECS)) dut (
    .clock(clock), .reset(reset), .coin_100(coin_100), .coin_500(coin_500),
    .coffee_type(coffee_type), .start(start), .cancel(cancel),
    .credit(credit), .change(change), .change_valid(change_valid),
    .coin_reject(coin_reject), .insufficient(insufficient),
    .water(water), .coffee(coffee), .sugar(sugar), .milk(milk),
    .chocolate(chocolate), .finished(finished), .busy(busy), .state(state)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Event kinds: 1 change (value=change), 2 coin reject (value=credit), 3 insufficient (value=credit).
  typedef struct {int kind; int val;} ev_t;
  typedef struct {int st; int len;} seg_t;
  ev_t  ev_q[$];
  seg_t seg_q[$];

  int exp_credit = 0;
  bit aborting = 1'b0;
  int price_tbl[4] = '{4, 6, 7, 5};
  int dur_tbl[4][5] = '{'{3, 2, 1, 0, 0}, '{1, 2, 1, 3, 0}, '{1, 2, 1, 2, 3}, '{1, 1, 0, 3, 0}};

  logic [6:0] outs;
  assign outs = {busy, water, coffee, sugar, milk, chocolate, finished};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [6:0] exp_outs(input int st);
    logic [6:0] v;
    v = 7'b0;
    if (st != 0) v[6] = 1'b1;
    if (st >= 1 && st <= 6) v[6 - st] = 1'b1;
    return v;
  endfunction

  task automatic pop_ev(input int kind, input int val, input string name);
    ev_t e;
    if (ev_q.size() == 0) begin
      fail({name, " unexpected pulse"});
    end else begin
      e = ev_q.pop_front();
      check({name, " kind"}, kind, e.kind);
      check({name, " value"}, val, e.val);
    end
  endtask

  // Monitor: pulses pop the event queue, state run lengths pop the segment queue.
  int run_st = 0;
  int run_len = 0;
  bit run_bad = 1'b0;
  always @(negedge clock) begin
    seg_t s;
    if (!reset || aborting) begin
      run_st = 0; run_len = 0; run_bad = 1'b0;
      seg_q.delete();
    end else begin
      if (change_valid) pop_ev(1, int'(change), "change_valid");
      if (coin_reject)  pop_ev(2, int'(credit), "coin_reject");
      if (insufficient) pop_ev(3, int'(credit), "insufficient");
      if (int'(state) != run_st) begin
        if (run_st != 0) begin
          if (seg_q.size() == 0) begin
            fail("segment with no expectation");
          end else begin
            s = seg_q.pop_front();
            check("seg_state", run_st, s.st);
            check("seg_len", run_len, s.len);
            check("seg_outputs_bad", int'(run_bad), 0);
          end
        end
        run_st = int'(state); run_len = 0; run_bad = 1'b0;
        if (run_st != 0 && seg_q.size() == 0) fail("brew state entered unexpectedly");
      end
      if (run_st != 0) begin
        run_len++;
        if (seg_q.size() > 0 && outs != exp_outs(seg_q[0].st)) run_bad = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic coin_op(input bit c1, input bit c5, input bit brewing);
    int delta;
    delta = (c1 ? 1 : 0) + (c5 ? 5 : 0);
    if (!brewing && exp_credit + delta <= CMAX) exp_credit += delta;
    else ev_q.push_back('{2, exp_credit});
    coin_100 = c1; coin_500 = c5;
    tick();
    coin_100 = 1'b0; coin_500 = 1'b0;
    tick();
  endtask

  task automatic start_op(input int t, input bit with_cancel, output bit acc);
    acc = 1'b0;
    if (with_cancel) begin
      if (exp_credit > 0) begin
        ev_q.push_back('{1, exp_credit});
        exp_credit = 0;
      end
    end else if (exp_credit >= price_tbl[t]) begin
      ev_q.push_back('{1, exp_credit - price_tbl[t]});
      exp_credit = 0;
      acc = 1'b1;
      for (int i = 0; i < 5; i++)
        if (dur_tbl[t][i] > 0) seg_q.push_back('{i + 1, dur_tbl[t][i] * TPS});
      seg_q.push_back('{6, FSECS * TPS});
    end else begin
      ev_q.push_back('{3, exp_credit});
    end
    coffee_type = 2'(t); start = 1'b1; cancel = with_cancel;
    tick();
    start = 1'b0; cancel = 1'b0;
    coffee_type = 2'($urandom_range(0, 3));
  endtask

  task automatic cancel_op(input bit brewing);
    if (!brewing && exp_credit > 0) begin
      ev_q.push_back('{1, exp_credit});
      exp_credit = 0;
    end
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || state != 3'd0) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) fail({name, " timeout waiting for idle"});
    tick();
  endtask

  task automatic wait_state(input int st);
    int n;
    n = 0;
    while (int'(state) != st && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) fail("timeout waiting for brew state");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    coin_100 = 1'b1;
    #2;
    check("reset state", int'(state), 0);
    check("reset credit", int'(credit), 0);
    check("reset change", int'(change), 0);
    check("reset outputs", int'(outs), 0);
    check("reset pulses", int'({change_valid, coin_reject, insufficient}), 0);
    @(negedge clock);
    reset = 1'b1;
    tick(); tick();
    coin_100 = 1'b0;
    tick(); tick();
    check("coin held through reset", int'(credit), 0);

    // Americano: credit 1,2,7 then change 3
    coin_op(1, 0, 0); check("credit after 100", int'(credit), 1);
    coin_op(1, 0, 0); check("credit after 2x100", int'(credit), 2);
    coin_op(0, 1, 0); check("credit after 500", int'(credit), 7);
    start_op(0, 0, acc);
    wait_idle("americano");
    check("americano change", int'(change), 3);
    check("americano credit", int'(credit), exp_credit);

    // Insufficient mocha, then refund
    coin_op(0, 1, 0);
    start_op(2, 0, acc);
    check("insufficient state", int'(state), 0);
    check("insufficient credit", int'(credit), 5);
    cancel_op(0);
    check("refund change", int'(change), 5);
    check("refund credit", int'(credit), 0);

    // Ceiling behaviour
    coin_op(0, 1, 0);
    for (int i = 0; i < 4; i++) coin_op(1, 0, 0);
    check("credit 9", int'(credit), 9);
    coin_op(0, 1, 0); check("reject keeps 9", int'(credit), 9);
    coin_op(1, 0, 0); check("credit 10", int'(credit), 10);
    coin_op(1, 0, 0); check("reject keeps 10", int'(credit), 10);
    cancel_op(0);

    // Latte with exact credit: change 0, sugar skipped
    coin_op(0, 1, 0);
    start_op(3, 0, acc);
    wait_idle("latte");
    check("latte change", int'(change), 0);

    // Cappuccino interrupted mid-milk
    coin_op(1, 1, 0); check("combined coin credit", int'(credit), 6);
    start_op(1, 0, acc);
    wait_state(4);
    coin_op(0, 1, 1);
    cancel_op(1);
    check("midbrew state", int'(state), 4);
    check("midbrew credit", int'(credit), 0);
    aborting = 1'b1;
    #3;
    reset = 1'b0;
    #1;
    check("async reset state", int'(state), 0);
    check("async reset outputs", int'(outs), 0);
    check("async reset credit", int'(credit), 0);
    @(negedge clock);
    reset = 1'b1;
    exp_credit = 0;
    tick();
    aborting = 1'b0;
    check("events drained at abort", ev_q.size(), 0);

    // start+cancel together: refund wins
    coin_op(1, 1, 0);
    start_op(1, 1, acc);
    check("start+cancel state", int'(state), 0);
    check("start+cancel change", int'(change), 6);
    check("start+cancel credit", int'(credit), 0);

    // Randomized mix
    for (int n = 0; n < 80; n++) begin
      int op;
      op = int'($urandom_range(0, 5));
      case (op)
        0: coin_op(1, 0, 0);
        1: coin_op(0, 1, 0);
        2: coin_op(1, 1, 0);
        3, 4: begin
          start_op(int'($urandom_range(0, 3)), 1'b0, acc);
          if (acc) begin
            if ($urandom_range(0, 1) == 1) coin_op(1'($urandom_range(0, 1)), 1'b1, 1'b1);
            if ($urandom_range(0, 1) == 1) cancel_op(1'b1);
            wait_idle("random brew");
          end
        end
        default: begin
          if ($urandom_range(0, 1) == 1) cancel_op(1'b0);
          else start_op(int'($urandom_range(0, 3)), 1'b1, acc);
        end
      endcase
      check("random credit", int'(credit), exp_credit);
    end

    repeat (3) tick();
    check("events left", ev_q.size(), 0);
    check("segments left", seg_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/brew_sequencer.md
Name: brew_sequencer

Overview:
- Single-block controller for the coffee vending datapath.
- Accumulates coin credit and checks it against the price of the selected drink.
- Computes change and sequences the ingredient valves (water, coffee, sugar, milk, chocolate), each for its per-drink duration.
- Replaces the hand-wired chain of coin counter, comparator, subtractor, timer and FSM with one clocked scheduler whose credit, change and state feed the existing 7-segment display modules.

Parameters:
- TICKS_PER_SEC, 50000000, clock cycles per one-second time unit (benches use 4).
- CREDIT_MAX, 10, credit ceiling in units of 100 (10 = 1000).
- FINISH_SECS, 1, seconds the finished indicator is held.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- coin_100  in  1  level from coin slot; each rising edge = +1 unit.
- coin_500  in  1  level from coin slot; each rising edge = +5 units.
- coffee_type  in  2  drink select; sampled only on accepted start.
- start  in  1  request brew; sampled each cycle in IDLE.
- cancel  in  1  refund request; honoured only in IDLE.
- credit  out  4  current credit, units of 100.
- change  out  4  last change amount, units of 100; held until next change event.
- change_valid  out  1  one-cycle pulse when change is loaded.
- coin_reject  out  1  one-cycle pulse when a coin edge is refused.
- insufficient  out  1  one-cycle pulse on start with credit below price.
- water / coffee / sugar / milk / chocolate  out  1 each  valve enables.
- finished  out  1  drink-ready indicator.
- busy  out  1  high in any state other than IDLE.
- state  out  3  current FSM state code.

Behaviour:
Reset (reset=0, async):
- state=IDLE; credit, change and all pulses/valves/finished = 0.
- Edge detectors preload so a coin held high during reset does not count.
- Reset mid-brew aborts immediately; credit is lost.

Coins:
- Rising edges detected via registered previous level.
- Delta = 1 for a coin_100 edge, 5 for a coin_500 edge, 6 for both in the same cycle.
- Accepted only in IDLE and only if credit+delta ≤ CREDIT_MAX. Otherwise credit is unchanged and coin_reject pulses; a combined-edge delta is accepted or rejected whole.
- Credit updates on the cycle after the edge is seen.

Price table (coffee_type: price; water/coffee/sugar/milk/chocolate in seconds):
- 00 americano: price 4; 3/2/1/0/0.
- 01 cappuccino: price 6; 1/2/1/3/0.
- 10 mocha: price 7; 1/2/1/2/3.
- 11 latte: price 5; 1/1/0/3/0.

States and codes:
- IDLE=0, WATER=1, COFFEE=2, SUGAR=3, MILK=4, CHOC=5, DONE=6; code 7 is illegal and goes to IDLE.

IDLE:
- cancel has priority over start in the same cycle.
- cancel with credit>0: change←credit, change_valid pulses, credit←0. With credit=0 it has no effect.
- start with credit ≥ price: coffee_type is latched, change←credit−price, change_valid pulses (even when change=0), credit←0, and the next state is the first step with non-zero duration.
- start with credit < price: insufficient pulses; state and credit are unchanged.
- A coin edge in the same cycle as an accepted start is rejected.

Ingredient states:
- Each valve is a Moore output, high exactly while in its state; it asserts on the first cycle after the start edge.
- Each state lasts exactly duration×TICKS_PER_SEC cycles.
- On exit, the FSM goes to the next step with non-zero duration in order WATER→COFFEE→SUGAR→MILK→CHOC, else DONE. Zero-duration steps consume no cycles.
- The tick and second counters clear on every state entry.
- start, cancel and coin edges during brewing are ignored; coin edges also pulse coin_reject.

DONE:
- finished is high for FINISH_SECS×TICKS_PER_SEC cycles, then state returns to IDLE.

Width rules:
- Prices and durations are constant tables; change subtraction is 4-bit and cannot underflow because of the price check.
- Counters are sized from parameters via $clog2.

Test Plan:
- TICKS_PER_SEC=4. coin_100 ×2, coin_500 ×1 (edges), coffee_type=00, start → credit 1,2,7; change=3 with change_valid pulse; water 12 cycles, coffee 8, sugar 4, no milk/chocolate; finished 4 cycles; state returns to 0.
- Credit 5, type=10 (price 7), start → insufficient pulse, state stays 0, credit stays 5. Then cancel → change=5, credit=0.
- Credit 9, then coin_500 → coin_reject, credit stays 9. Then coin_100 → credit 10. Then coin_100 again → coin_reject.
- Type=11 with credit 5 → change=0 and change_valid pulse. Sequence is water 4, coffee 4, milk 12 cycles; the sugar step is skipped with state going 2→4 directly.
- Mid-MILK during type=01: coin_500 edge → coin_reject with credit unchanged; cancel ignored. Then reset low for 1 cycle → all valves 0, state 0, credit 0 immediately (asynchronous).
- start and cancel together with credit 6 → refund path taken (change=6, state stays 0); coin_100 and coin_500 edges together at credit 0 → credit 6.
